// File: rtl/mult_share_scheduler_if.sv
// Request/result bundle for one scheduler port: a valid/ready request channel
// plus the registered result strobe returned to the same requester.
interface mult_share_scheduler_if #(
  parameter int TAG_W = 4
);
  logic             valid;
  logic             ready;
  logic [8:0]       a;
  logic [8:0]       b;
  logic             sign;
  logic             half;
  logic [TAG_W-1:0] tag;
  logic             res_valid;
  logic [17:0]      res_c;
  logic [TAG_W-1:0] res_tag;

  // Requester side
  modport master (
    output valid, a, b, sign, half, tag,
    input  ready, res_valid, res_c, res_tag
  );

  // Scheduler side
  modport slave (
    input  valid, a, b, sign, half, tag,
    output ready, res_valid, res_c, res_tag
  );
endinterface

// File: rtl/mult_share_scheduler.sv
// Two-port round-robin scheduler for the shared 9x9 fracturable multiplier.
// Compatible 4x4 requests from both ports are packed into one HALF_1 operation.
// Pipeline: accept -> issue register -> multiplier (comb) -> result register.
module mult_share_scheduler #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  mult_share_scheduler_if.slave req0,
  mult_share_scheduler_if.slave req1,
  output logic [CNT_W-1:0]     op_count,
  output logic [CNT_W-1:0]     pack_count
);

  localparam logic [1:0] MODE_FULL = 2'd0;
  localparam logic [1:0] MODE_HALF = 2'd1;
  localparam logic [1:0] MODE_PACK = 2'd2;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Two's-complement (or plain) 4x4 product, 8-bit lane
  function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y, input logic sgn);
    logic [7:0] xe;
    logic [7:0] ye;
    xe = sgn ? {{4{x[3]}}, x} : {4'b0000, x};
    ye = sgn ? {{4{y[3]}}, y} : {4'b0000, y};
    return xe * ye;
  endfunction

  // Two's-complement (or plain) 9x9 product, 18-bit result
  function automatic logic [17:0] mul9(input logic [8:0] x, input logic [8:0] y, input logic sgn);
    logic [17:0] xe;
    logic [17:0] ye;
    xe = sgn ? {{9{x[8]}}, x} : {9'b0_0000_0000, x};
    ye = sgn ? {{9{y[8]}}, y} : {9'b0_0000_0000, y};
    return xe * ye;
  endfunction

  // Widen an 8-bit half-mode lane to 18 bits according to the request sign
  function automatic logic [17:0] ext8(input logic [7:0] v, input logic sgn);
    return sgn ? {{10{v[7]}}, v} : {10'b00_0000_0000, v};
  endfunction

  logic [1:0]       grant_s;
  logic             pack_s;
  logic [8:0]       sel_a_s, sel_b_s;
  logic             sel_sign_s, sel_half_s;
  logic [17:0]      mul_c_s;
  logic [17:0]      lane0_c_s, lane1_c_s;

  logic             iss_valid_d, iss_valid_q;
  logic [8:0]       iss_a_d, iss_a_q;
  logic [8:0]       iss_b_d, iss_b_q;
  logic             iss_half0_d, iss_half0_q;
  logic             iss_half1_d, iss_half1_q;
  logic [1:0]       iss_mode_d, iss_mode_q;
  logic [1:0]       iss_mask_d, iss_mask_q;
  logic             iss_sign_d, iss_sign_q;
  logic [TAG_W-1:0] iss_tag0_d, iss_tag0_q;
  logic [TAG_W-1:0] iss_tag1_d, iss_tag1_q;

  logic             res0_valid_d, res0_valid_q;
  logic [17:0]      res0_c_d, res0_c_q;
  logic [TAG_W-1:0] res0_tag_d, res0_tag_q;
  logic             res1_valid_d, res1_valid_q;
  logic [17:0]      res1_c_d, res1_c_q;
  logic [TAG_W-1:0] res1_tag_d, res1_tag_q;

  logic             last_d, last_q;
  logic [CNT_W-1:0] op_count_d, op_count_q;
  logic [CNT_W-1:0] pack_count_d, pack_count_q;

  // Grant decision: pack compatible halves, else round-robin single grant
  always_comb begin
    grant_s = 2'b00;
    pack_s  = 1'b0;
    if (reset) begin
      grant_s = 2'b00;
    end else if (req0.valid && req1.valid && req0.half && req1.half &&
                 (req0.sign == req1.sign)) begin
      grant_s = 2'b11;
      pack_s  = 1'b1;
    end else if (req0.valid && req1.valid) begin
      // last_q names the port granted most recently; the other one wins
      grant_s = last_q ? 2'b01 : 2'b10;
    end else if (req0.valid) begin
      grant_s = 2'b01;
    end else if (req1.valid) begin
      grant_s = 2'b10;
    end else begin
      grant_s = 2'b00;
    end
  end

  assign req0.ready = grant_s[0];
  assign req1.ready = grant_s[1];

  // Operand selection for a single (unpacked) grant
  always_comb begin
    if (grant_s == 2'b10) begin
      sel_a_s    = req1.a;
      sel_b_s    = req1.b;
      sel_sign_s = req1.sign;
      sel_half_s = req1.half;
    end else begin
      sel_a_s    = req0.a;
      sel_b_s    = req0.b;
      sel_sign_s = req0.sign;
      sel_half_s = req0.half;
    end
  end

  // Issue register next state: multiplier inputs, mode, owners and tags
  always_comb begin
    iss_valid_d = (grant_s != 2'b00);
    iss_a_d     = iss_a_q;
    iss_b_d     = iss_b_q;
    iss_half0_d = iss_half0_q;
    iss_half1_d = iss_half1_q;
    iss_mode_d  = iss_mode_q;
    iss_sign_d  = iss_sign_q;
    iss_tag0_d  = iss_tag0_q;
    iss_tag1_d  = iss_tag1_q;
    iss_mask_d  = grant_s;
    case (grant_s)
      2'b11: begin
        // req0 rides the upper lane, req1 the lower lane; bit 4 is the guard gap
        iss_a_d     = {req0.a[3:0], 1'b0, req1.a[3:0]};
        iss_b_d     = {req0.b[3:0], 1'b0, req1.b[3:0]};
        iss_half0_d = 1'b0;
        iss_half1_d = 1'b1;
        iss_mode_d  = MODE_PACK;
        iss_sign_d  = req0.sign;
        iss_tag0_d  = req0.tag;
        iss_tag1_d  = req1.tag;
      end
      2'b01, 2'b10: begin
        if (sel_half_s) begin
          iss_a_d     = {5'b0_0000, sel_a_s[3:0]};
          iss_b_d     = {5'b0_0000, sel_b_s[3:0]};
          iss_half0_d = 1'b0;
          iss_half1_d = 1'b1;
          iss_mode_d  = MODE_HALF;
        end else begin
          iss_a_d     = sel_a_s;
          iss_b_d     = sel_b_s;
          iss_half0_d = 1'b1;
          iss_half1_d = 1'b0;
          iss_mode_d  = MODE_FULL;
        end
        iss_sign_d = sel_sign_s;
        if (grant_s[0]) begin
          iss_tag0_d = req0.tag;
        end else begin
          iss_tag1_d = req1.tag;
        end
      end
      default: begin
        iss_a_d = iss_a_q;
      end
    endcase
  end

  // Shared multiplier model: full 9x9 or two independent 4x4 lanes
  always_comb begin
    mul_c_s = 18'h0_0000;
    if (iss_half1_q) begin
      mul_c_s[7:0]   = mul4(iss_a_q[3:0], iss_b_q[3:0], iss_sign_q);
      mul_c_s[17:10] = mul4(iss_a_q[8:5], iss_b_q[8:5], iss_sign_q);
    end else if (iss_half0_q) begin
      mul_c_s = mul9(iss_a_q, iss_b_q, iss_sign_q);
    end else begin
      mul_c_s = 18'h0_0000;
    end
  end

  // Per-owner view of the multiplier output
  always_comb begin
    case (iss_mode_q)
      MODE_FULL: begin
        lane0_c_s = mul_c_s;
        lane1_c_s = mul_c_s;
      end
      MODE_HALF: begin
        lane0_c_s = ext8(mul_c_s[7:0], iss_sign_q);
        lane1_c_s = ext8(mul_c_s[7:0], iss_sign_q);
      end
      MODE_PACK: begin
        lane0_c_s = ext8(mul_c_s[17:10], iss_sign_q);
        lane1_c_s = ext8(mul_c_s[7:0], iss_sign_q);
      end
      default: begin
        lane0_c_s = mul_c_s;
        lane1_c_s = mul_c_s;
      end
    endcase
  end

  // Result register next state: strobe and route to the owning port(s)
  always_comb begin
    res0_valid_d = iss_valid_q && iss_mask_q[0];
    res1_valid_d = iss_valid_q && iss_mask_q[1];
    if (res0_valid_d) begin
      res0_c_d   = lane0_c_s;
      res0_tag_d = iss_tag0_q;
    end else begin
      res0_c_d   = res0_c_q;
      res0_tag_d = res0_tag_q;
    end
    if (res1_valid_d) begin
      res1_c_d   = lane1_c_s;
      res1_tag_d = iss_tag1_q;
    end else begin
      res1_c_d   = res1_c_q;
      res1_tag_d = res1_tag_q;
    end
  end

  // Round-robin pointer and statistics counters
  always_comb begin
    case (grant_s)
      2'b01:   last_d = 1'b0;
      2'b10:   last_d = 1'b1;
      default: last_d = last_q;
    endcase
    if (grant_s != 2'b00) begin
      op_count_d = op_count_q + CNT_ONE;
    end else begin
      op_count_d = op_count_q;
    end
    if (pack_s) begin
      pack_count_d = pack_count_q + CNT_ONE;
    end else begin
      pack_count_d = pack_count_q;
    end
  end

  // State registers; reset drops any in-flight operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iss_valid_q  <= 1'b0;
      iss_a_q      <= 9'h000;
      iss_b_q      <= 9'h000;
      iss_half0_q  <= 1'b0;
      iss_half1_q  <= 1'b0;
      iss_mode_q   <= MODE_FULL;
      iss_mask_q   <= 2'b00;
      iss_sign_q   <= 1'b0;
      iss_tag0_q   <= '0;
      iss_tag1_q   <= '0;
      res0_valid_q <= 1'b0;
      res0_c_q     <= 18'h0_0000;
      res0_tag_q   <= '0;
      res1_valid_q <= 1'b0;
      res1_c_q     <= 18'h0_0000;
      res1_tag_q   <= '0;
      last_q       <= 1'b1;
      op_count_q   <= '0;
      pack_count_q <= '0;
    end else begin
      iss_valid_q  <= iss_valid_d;
      iss_a_q      <= iss_a_d;
      iss_b_q      <= iss_b_d;
      iss_half0_q  <= iss_half0_d;
      iss_half1_q  <= iss_half1_d;
      iss_mode_q   <= iss_mode_d;
      iss_mask_q   <= iss_mask_d;
      iss_sign_q   <= iss_sign_d;
      iss_tag0_q   <= iss_tag0_d;
      iss_tag1_q   <= iss_tag1_d;
      res0_valid_q <= res0_valid_d;
      res0_c_q     <= res0_c_d;
      res0_tag_q   <= res0_tag_d;
      res1_valid_q <= res1_valid_d;
      res1_c_q     <= res1_c_d;
      res1_tag_q   <= res1_tag_d;
      last_q       <= last_d;
      op_count_q   <= op_count_d;
      pack_count_q <= pack_count_d;
    end
  end

  assign req0.res_valid = res0_valid_q;
  assign req0.res_c     = res0_c_q;
  assign req0.res_tag   = res0_tag_q;
  assign req1.res_valid = res1_valid_q;
  assign req1.res_c     = res1_c_q;
  assign req1.res_tag   = res1_tag_q;
  assign op_count       = op_count_q;
  assign pack_count     = pack_count_q;

endmodule
